// File: rtl/sdram_read_arbiter_pkg.sv
// Shared types and constants for the two-port SDRAM burst-read arbiter.
//   arb_state_e : arbiter FSM encoding (IDLE / ISSUE / BURST)
//   port_e      : requester identifiers (video preload, general reads)
//   rd_req_t    : latched burst request (word address + beat count)
package sdram_read_arbiter_pkg;

    localparam int ADDR_W    = 23;
    localparam int LEN_W     = 9;
    localparam int DATA_W    = 32;
    localparam int CONSEC_W  = 4;
    localparam int WD_W      = 10;
    localparam int NUM_PORTS = 2;

    localparam logic TRUE  = 1'b1;
    localparam logic FALSE = 1'b0;

    typedef enum logic [1:0] {
        ARB_IDLE  = 2'd0,
        ARB_ISSUE = 2'd1,
        ARB_BURST = 2'd2
    } arb_state_e;

    typedef enum logic {
        PORT_VIDEO   = 1'b0,
        PORT_GENERAL = 1'b1
    } port_e;

    typedef struct packed {
        logic [ADDR_W-1:0] address;
        logic [LEN_W-1:0]  burst_length;
    } rd_req_t;

endpackage

// File: rtl/sdram_read_arbiter_latch.sv
// Per-port request holding register.
//   clk_i, reset_i : clock, synchronous active-low reset
//   request_i      : one-cycle request pulse, req_i sampled with it
//   active_i       : this port owns the burst currently in flight
//   grant_i        : arbiter picked this port; clears the pending flag
//   pending_o      : a latched request is waiting for arbitration
//   req_o          : latched address / beat count
//   overrun_o      : registered pulse, a request was dropped
module read_request_latch
    import sdram_read_arbiter_pkg::*;
(
    input  logic    clk_i,
    input  logic    reset_i,
    input  logic    request_i,
    input  rd_req_t req_i,
    input  logic    active_i,
    input  logic    grant_i,
    output logic    pending_o,
    output rd_req_t req_o,
    output logic    overrun_o
);

    logic    pending_q, pending_d;
    rd_req_t req_q, req_d;
    logic    overrun_q, overrun_d;
    logic    accept;

    always_comb begin
        accept    = request_i && !pending_q && !active_i;
        overrun_d = request_i && !accept;
        pending_d = pending_q;
        req_d     = req_q;
        if (grant_i) pending_d = FALSE;
        // grant needs pending_q set, so it never coincides with accept
        if (accept) begin
            pending_d = TRUE;
            req_d     = req_i;
        end
    end

    always_ff @(posedge clk_i) begin
        if (!reset_i) begin
            pending_q <= FALSE;
            req_q     <= '0;
            overrun_q <= FALSE;
        end else begin
            pending_q <= pending_d;
            req_q     <= req_d;
            overrun_q <= overrun_d;
        end
    end

    assign pending_o = pending_q;
    assign req_o     = req_q;
    assign overrun_o = overrun_q;

endmodule

// File: rtl/sdram_read_arbiter.sv
// Shares one SDRAM burst-read port between the video row preload (port 0,
// fixed priority) and general reads (port 1, protected by an anti-starvation
// limit). One burst in flight at a time; beats are registered and routed to
// the burst owner until the programmed count, or until the watchdog aborts.
//   clk_i, reset_i         : clock, synchronous active-low reset
//   reqN_request_i/_address_i/_burst_length_i : request pulse + parameters
//   reqN_available_o, req_data_o              : forwarded beat (registered)
//   reqN_done_o, reqN_overrun_o, timeout_error_o : status pulses
//   rd_request_o, rd_address_o, rd_burst_length_o : SDRAM controller request
//   rd_available_i, rd_data_i                 : SDRAM read data
module sdram_read_arbiter
    import sdram_read_arbiter_pkg::*;
#(
    parameter int MAX_CONSEC = 4,
    parameter int TIMEOUT    = 1023
) (
    input  logic              clk_i,
    input  logic              reset_i,
    input  logic              req0_request_i,
    input  logic [ADDR_W-1:0] req0_address_i,
    input  logic [LEN_W-1:0]  req0_burst_length_i,
    input  logic              req1_request_i,
    input  logic [ADDR_W-1:0] req1_address_i,
    input  logic [LEN_W-1:0]  req1_burst_length_i,
    output logic              req0_available_o,
    output logic              req1_available_o,
    output logic [DATA_W-1:0] req_data_o,
    output logic              req0_done_o,
    output logic              req1_done_o,
    output logic              req0_overrun_o,
    output logic              req1_overrun_o,
    output logic              timeout_error_o,
    output logic              rd_request_o,
    output logic [ADDR_W-1:0] rd_address_o,
    output logic [LEN_W-1:0]  rd_burst_length_o,
    input  logic              rd_available_i,
    input  logic [DATA_W-1:0] rd_data_i
);

    localparam logic [CONSEC_W-1:0] MAX_C   = CONSEC_W'(MAX_CONSEC);
    localparam logic [WD_W-1:0]     WD_LAST = WD_W'(TIMEOUT - 1);

    arb_state_e state_q, state_d;
    port_e      owner_q, owner_d, sel;
    logic       sel_valid;

    logic [CONSEC_W-1:0] consec_q, consec_d;
    logic [LEN_W-1:0]    beat_q, beat_d, beat_inc;
    logic [WD_W-1:0]     wd_q, wd_d;
    logic [ADDR_W-1:0]   rd_addr_q, rd_addr_d;
    logic [LEN_W-1:0]    rd_len_q, rd_len_d;
    logic [NUM_PORTS-1:0] avail_q, avail_d, done_q, done_d;
    logic                tmo_q, tmo_d;
    logic [DATA_W-1:0]   data_q, data_d;

    logic    [NUM_PORTS-1:0] request, pending, active, grant, overrun;
    rd_req_t [NUM_PORTS-1:0] req_in, req_lat;

    assign request   = {req1_request_i, req0_request_i};
    assign req_in[0] = {req0_address_i, req0_burst_length_i};
    assign req_in[1] = {req1_address_i, req1_burst_length_i};

    for (genvar p = 0; p < NUM_PORTS; p++) begin : g_port
        assign active[p] = (state_q != ARB_IDLE) && (owner_q == port_e'(p));

        read_request_latch u_latch (
            .clk_i     (clk_i),
            .reset_i   (reset_i),
            .request_i (request[p]),
            .req_i     (req_in[p]),
            .active_i  (active[p]),
            .grant_i   (grant[p]),
            .pending_o (pending[p]),
            .req_o     (req_lat[p]),
            .overrun_o (overrun[p])
        );
    end

    // state register
    always_ff @(posedge clk_i) begin
        if (!reset_i) state_q <= ARB_IDLE;
        else          state_q <= state_d;
    end

    // next state plus datapath next values
    always_comb begin
        state_d   = state_q;
        owner_d   = owner_q;
        sel       = PORT_VIDEO;
        sel_valid = FALSE;
        grant     = '0;
        consec_d  = consec_q;
        beat_inc  = beat_q + 1'b1;
        beat_d    = beat_q;
        wd_d      = wd_q;
        rd_addr_d = rd_addr_q;
        rd_len_d  = rd_len_q;
        avail_d   = '0;
        done_d    = '0;
        tmo_d     = FALSE;
        data_d    = data_q;

        case (state_q)
            ARB_IDLE: begin
                if (!pending[PORT_GENERAL]) consec_d = '0;
                // Sit out the cycle a done pulse is visible so the finishing
                // port's immediate re-request gets to compete for the next slot.
                if (done_q == '0) begin
                    if (pending[PORT_VIDEO] &&
                        !(pending[PORT_GENERAL] && consec_q == MAX_C)) begin
                        sel       = PORT_VIDEO;
                        sel_valid = TRUE;
                    end else if (pending[PORT_GENERAL]) begin
                        sel       = PORT_GENERAL;
                        sel_valid = TRUE;
                    end
                end
                if (sel_valid) begin
                    grant[sel] = TRUE;
                    owner_d    = sel;
                    rd_addr_d  = req_lat[sel].address;
                    rd_len_d   = req_lat[sel].burst_length;
                    if (sel == PORT_GENERAL)
                        consec_d = '0;
                    else if (pending[PORT_GENERAL] && consec_q < MAX_C)
                        consec_d = consec_q + 1'b1;
                    // zero-length request completes without touching the SDRAM
                    if (req_lat[sel].burst_length == '0) done_d[sel] = TRUE;
                    else                                 state_d     = ARB_ISSUE;
                end
            end
            ARB_ISSUE: begin
                beat_d  = '0;
                wd_d    = '0;
                state_d = ARB_BURST;
            end
            ARB_BURST: begin
                if (rd_available_i) begin
                    avail_d[owner_q] = TRUE;
                    data_d           = rd_data_i;
                    beat_d           = beat_inc;
                    wd_d             = '0;
                    if (beat_inc == rd_len_q) begin
                        done_d[owner_q] = TRUE;
                        state_d         = ARB_IDLE;
                    end
                end else if (wd_q == WD_LAST) begin
                    tmo_d           = TRUE;
                    done_d[owner_q] = TRUE;
                    state_d         = ARB_IDLE;
                end else begin
                    wd_d = wd_q + 1'b1;
                end
            end
            default: state_d = ARB_IDLE;
        endcase
    end

    // FSM output
    always_comb begin
        rd_request_o = FALSE;
        if (state_q == ARB_ISSUE) rd_request_o = TRUE;
    end

    always_ff @(posedge clk_i) begin
        if (!reset_i) begin
            owner_q   <= PORT_VIDEO;
            consec_q  <= '0;
            beat_q    <= '0;
            wd_q      <= '0;
            rd_addr_q <= '0;
            rd_len_q  <= '0;
            avail_q   <= '0;
            done_q    <= '0;
            tmo_q     <= FALSE;
            data_q    <= '0;
        end else begin
            owner_q   <= owner_d;
            consec_q  <= consec_d;
            beat_q    <= beat_d;
            wd_q      <= wd_d;
            rd_addr_q <= rd_addr_d;
            rd_len_q  <= rd_len_d;
            avail_q   <= avail_d;
            done_q    <= done_d;
            tmo_q     <= tmo_d;
            data_q    <= data_d;
        end
    end

    assign req0_available_o  = avail_q[PORT_VIDEO];
    assign req1_available_o  = avail_q[PORT_GENERAL];
    assign req0_done_o       = done_q[PORT_VIDEO];
    assign req1_done_o       = done_q[PORT_GENERAL];
    assign req0_overrun_o    = overrun[PORT_VIDEO];
    assign req1_overrun_o    = overrun[PORT_GENERAL];
    assign timeout_error_o   = tmo_q;
    assign req_data_o        = data_q;
    assign rd_address_o      = rd_addr_q;
    assign rd_burst_length_o = rd_len_q;

endmodule

// File: tb/tb_sdram_read_arbiter.sv
// Directed bench for sdram_read_arbiter. Inputs change 1 time unit after the
// rising edge; outputs are sampled at the same point, so each observation
// shows the registers updated by the edge just passed.
module tb_sdram_read_arbiter;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        r0, r1;
    logic [22:0] a0, a1;
    logic [8:0]  l0, l1;
    logic        rd_av;
    logic [31:0] rd_dat;

    logic        av0_o, av1_o, dn0_o, dn1_o, ov0_o, ov1_o, tmo_o, rdreq_o;
    logic [31:0] data_o;
    logic [22:0] rdaddr_o;
    logic [8:0]  rdlen_o;
    logic [7:0]  outs;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    sdram_read_arbiter #(.MAX_CONSEC(4), .TIMEOUT(1023)) dut (
        .clk_i               (clk),
        .reset_i             (rst_n),
        .req0_request_i      (r0),
        .req0_address_i      (a0),
        .req0_burst_length_i (l0),
        .req1_request_i      (r1),
        .req1_address_i      (a1),
        .req1_burst_length_i (l1),
        .req0_available_o    (av0_o),
        .req1_available_o    (av1_o),
        .req_data_o          (data_o),
        .req0_done_o         (dn0_o),
        .req1_done_o         (dn1_o),
        .req0_overrun_o      (ov0_o),
        .req1_overrun_o      (ov1_o),
        .timeout_error_o     (tmo_o),
        .rd_request_o        (rdreq_o),
        .rd_address_o        (rdaddr_o),
        .rd_burst_length_o   (rdlen_o),
        .rd_available_i      (rd_av),
        .rd_data_i           (rd_dat)
    );

    assign outs = {av0_o, av1_o, dn0_o, dn1_o, ov0_o, ov1_o, tmo_o, rdreq_o};

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Steps until rd_request is seen (waited = cycles stepped) or gives up
    // (waited = -1). Request pulses are dropped after the first edge.
    task automatic wait_rd_request(input int limit, output int waited);
        waited = -1;
        for (int c = 1; c <= limit; c++) begin
            step();
            r0 = 1'b0;
            r1 = 1'b0;
            if (rdreq_o === 1'b1) begin
                waited = c;
                break;
            end
        end
    endtask

    // Drives n consecutive beats (data = seed + i) and tallies what comes back.
    task automatic feed(input int n, input logic [31:0] seed, input bit rereq0,
                        output int av0, output int av1, output int dn0, output int dn1,
                        output int bad, output int rq, output int ov,
                        output logic [1:0] last_done);
        av0 = 0; av1 = 0; dn0 = 0; dn1 = 0; bad = 0; rq = 0; ov = 0;
        last_done = 2'b00;
        for (int i = 0; i < n; i++) begin
            rd_av  = 1'b1;
            rd_dat = seed + 32'(i);
            step();
            av0 += int'(av0_o);
            av1 += int'(av1_o);
            dn0 += int'(dn0_o);
            dn1 += int'(dn1_o);
            rq  += int'(rdreq_o);
            ov  += int'(ov0_o) + int'(ov1_o);
            if ((av0_o || av1_o) && data_o !== seed + 32'(i)) bad++;
            if (i == n - 1) last_done = {dn1_o, dn0_o};
        end
        rd_av  = 1'b0;
        rd_dat = '0;
        if (rereq0) r0 = 1'b1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; r0 = 1'b0; r1 = 1'b0;
        a0 = '0; a1 = '0; l0 = '0; l1 = '0;
        rd_av = 1'b1; rd_dat = 32'hFFFF_FFFF;
        repeat (3) step();
        checks++; if (outs !== 8'h00) begin failures++; $display("FAIL reset_outputs: got %b want 00000000", outs); end
        checks++; if (rdaddr_o !== 23'h0 || rdlen_o !== 9'h0) begin failures++; $display("FAIL reset_rd_params: got addr %h len %0d want 0/0", rdaddr_o, rdlen_o); end
        checks++; if (data_o !== 32'h0) begin failures++; $display("FAIL reset_data: got %h want 0", data_o); end
        rst_n = 1'b1;
        step();
        rd_av = 1'b0; rd_dat = '0;
        checks++; if (outs !== 8'h00) begin failures++; $display("FAIL idle_stray_beat: got %b want 00000000", outs); end
    endtask

    task automatic test_single_port0();
        int w, av0, av1, dn0, dn1, bad, rq, ov;
        logic [1:0] ld;
        a0 = 23'h000100; l0 = 9'd88; r0 = 1'b1;
        wait_rd_request(10, w);
        checks++; if (w != 2) begin failures++; $display("FAIL single_issue_latency: got %0d want 2", w); end
        checks++; if (rdaddr_o !== 23'h000100 || rdlen_o !== 9'd88) begin failures++; $display("FAIL single_rd_params: got %h/%0d want 000100/88", rdaddr_o, rdlen_o); end
        step();
        feed(88, 32'hA500_0000, 1'b0, av0, av1, dn0, dn1, bad, rq, ov, ld);
        checks++; if (av0 != 88 || av1 != 0) begin failures++; $display("FAIL single_beats: got av0 %0d av1 %0d want 88/0", av0, av1); end
        checks++; if (ld !== 2'b01 || dn0 != 1 || dn1 != 0) begin failures++; $display("FAIL single_done: got last %b dn0 %0d dn1 %0d want 01/1/0", ld, dn0, dn1); end
        checks++; if (bad != 0) begin failures++; $display("FAIL single_data: got %0d bad beats want 0", bad); end
        checks++; if (rq != 0) begin failures++; $display("FAIL single_one_request: got %0d extra rd_request want 0", rq); end
    endtask

    task automatic test_simultaneous();
        int w, av0, av1, dn0, dn1, bad, rq, ov;
        logic [1:0] ld;
        a0 = 23'h000200; l0 = 9'd4; a1 = 23'h000300; l1 = 9'd4;
        r0 = 1'b1; r1 = 1'b1;
        wait_rd_request(10, w);
        checks++; if (w != 2 || rdaddr_o !== 23'h000200) begin failures++; $display("FAIL sim_first: got wait %0d addr %h want 2/000200", w, rdaddr_o); end
        step();
        feed(4, 32'h1111_0000, 1'b0, av0, av1, dn0, dn1, bad, rq, ov, ld);
        checks++; if (av0 != 4 || av1 != 0 || ld !== 2'b01 || bad != 0) begin failures++; $display("FAIL sim_port0_burst: got av0 %0d av1 %0d last %b bad %0d want 4/0/01/0", av0, av1, ld, bad); end
        wait_rd_request(10, w);
        checks++; if (w != 2) begin failures++; $display("FAIL sim_gap_after_done: got %0d want 2", w); end
        checks++; if (rdaddr_o !== 23'h000300 || rdlen_o !== 9'd4) begin failures++; $display("FAIL sim_second_params: got %h/%0d want 000300/4", rdaddr_o, rdlen_o); end
        step();
        feed(4, 32'h2222_0000, 1'b0, av0, av1, dn0, dn1, bad, rq, ov, ld);
        checks++; if (av1 != 4 || av0 != 0 || ld !== 2'b10 || bad != 0) begin failures++; $display("FAIL sim_port1_burst: got av1 %0d av0 %0d last %b bad %0d want 4/0/10/0", av1, av0, ld, bad); end
    endtask

    task automatic test_starvation();
        int w, av0, av1, dn0, dn1, bad, rq, ov, n0;
        logic [1:0] ld;
        logic [22:0] winner;
        a0 = 23'h000400; l0 = 9'd2; a1 = 23'h000500; l1 = 9'd2;
        r0 = 1'b1; r1 = 1'b1;
        n0 = 0; winner = '0; av1 = 0;
        for (int k = 0; k < 8; k++) begin
            wait_rd_request(10, w);
            if (w < 0) break;
            winner = rdaddr_o;
            step();
            if (winner == 23'h000400) begin
                n0++;
                feed(2, 32'h3300_0000 + 32'(k * 16), 1'b1, av0, av1, dn0, dn1, bad, rq, ov, ld);
            end else begin
                feed(2, 32'h3400_0000, 1'b0, av0, av1, dn0, dn1, bad, rq, ov, ld);
                break;
            end
        end
        checks++; if (n0 != 4) begin failures++; $display("FAIL starve_port0_count: got %0d want 4", n0); end
        checks++; if (winner !== 23'h000500 || av1 != 2) begin failures++; $display("FAIL starve_port1_served: got addr %h av1 %0d want 000500/2", winner, av1); end
        wait_rd_request(10, w);
        checks++; if (w != 2 || rdaddr_o !== 23'h000400) begin failures++; $display("FAIL starve_port0_after: got wait %0d addr %h want 2/000400", w, rdaddr_o); end
        step();
        feed(2, 32'h3500_0000, 1'b0, av0, av1, dn0, dn1, bad, rq, ov, ld);
    endtask

    task automatic test_overrun();
        int w, av0, av1, dn0, dn1, bad, rq, ov;
        logic [1:0] ld;
        a1 = 23'h000600; l1 = 9'd6; r1 = 1'b1;
        wait_rd_request(10, w);
        checks++; if (w != 2) begin failures++; $display("FAIL ovr_issue: got %0d want 2", w); end
        a1 = 23'h0006FF; r1 = 1'b1;
        step();
        r1 = 1'b0;
        checks++; if (ov1_o !== 1'b1 || ov0_o !== 1'b0) begin failures++; $display("FAIL ovr_pulse: got ov1 %b ov0 %b want 1/0", ov1_o, ov0_o); end
        feed(6, 32'h6600_0000, 1'b0, av0, av1, dn0, dn1, bad, rq, ov, ld);
        checks++; if (av1 != 6 || ld !== 2'b10 || ov != 0 || rq != 0) begin failures++; $display("FAIL ovr_burst: got av1 %0d last %b ov %0d rq %0d want 6/10/0/0", av1, ld, ov, rq); end
        wait_rd_request(20, w);
        checks++; if (w != -1 || rdaddr_o !== 23'h000600) begin failures++; $display("FAIL ovr_no_extra: got wait %0d addr %h want -1/000600", w, rdaddr_o); end
    endtask

    task automatic test_zero_len_timeout();
        int w, av0, av1, dn0, dn1, bad, rq, ov, j, extra;
        logic [1:0] ld;
        logic d;
        a1 = 23'h000700; l1 = 9'd0; r1 = 1'b1;
        step();
        r1 = 1'b0;
        checks++; if (dn1_o !== 1'b0 || rdreq_o !== 1'b0) begin failures++; $display("FAIL zero_early: got done %b rdreq %b want 0/0", dn1_o, rdreq_o); end
        step();
        checks++; if (dn1_o !== 1'b1 || rdreq_o !== 1'b0) begin failures++; $display("FAIL zero_done: got done %b rdreq %b want 1/0", dn1_o, rdreq_o); end
        wait_rd_request(10, w);
        checks++; if (w != -1) begin failures++; $display("FAIL zero_no_request: got %0d want -1", w); end

        a0 = 23'h000800; l0 = 9'd8; r0 = 1'b1;
        wait_rd_request(10, w);
        step();
        feed(3, 32'h8800_0000, 1'b0, av0, av1, dn0, dn1, bad, rq, ov, ld);
        checks++; if (av0 != 3 || ld !== 2'b00) begin failures++; $display("FAIL tmo_partial: got av0 %0d last %b want 3/00", av0, ld); end
        j = -1; extra = 0; d = 1'b0;
        for (int c = 1; c <= 1100; c++) begin
            step();
            extra += int'(av0_o) + int'(av1_o);
            if (tmo_o === 1'b1) begin
                j = c;
                d = dn0_o;
                break;
            end
        end
        checks++; if (j != 1023) begin failures++; $display("FAIL tmo_cycles: got %0d want 1023", j); end
        checks++; if (d !== 1'b1 || extra != 0) begin failures++; $display("FAIL tmo_done: got done %b extra %0d want 1/0", d, extra); end
        step();
        checks++; if (tmo_o !== 1'b0 || dn0_o !== 1'b0) begin failures++; $display("FAIL tmo_pulse: got tmo %b done %b want 0/0", tmo_o, dn0_o); end
    endtask

    task automatic test_reset_mid_burst();
        int w, av0, av1, dn0, dn1, bad, rq, ov, stray;
        logic [1:0] ld;
        a0 = 23'h000900; l0 = 9'd88; r0 = 1'b1;
        wait_rd_request(10, w);
        step();
        feed(10, 32'h9900_0000, 1'b0, av0, av1, dn0, dn1, bad, rq, ov, ld);
        checks++; if (av0 != 10) begin failures++; $display("FAIL rst_pre_beats: got %0d want 10", av0); end
        rst_n = 1'b0; rd_av = 1'b1; rd_dat = 32'hDEAD_0000;
        step();
        checks++; if (outs !== 8'h00 || data_o !== 32'h0) begin failures++; $display("FAIL rst_mid_outputs: got %b data %h want 00000000/0", outs, data_o); end
        checks++; if (rdaddr_o !== 23'h0 || rdlen_o !== 9'h0) begin failures++; $display("FAIL rst_mid_params: got %h/%0d want 0/0", rdaddr_o, rdlen_o); end
        rst_n = 1'b1; stray = 0;
        for (int i = 0; i < 78; i++) begin
            rd_dat = 32'hDEAD_0001 + 32'(i);
            step();
            stray += int'(av0_o) + int'(av1_o) + int'(dn0_o) + int'(dn1_o) + int'(rdreq_o);
        end
        rd_av = 1'b0; rd_dat = '0;
        checks++; if (stray != 0) begin failures++; $display("FAIL rst_stray_beats: got %0d events want 0", stray); end
        a1 = 23'h000A00; l1 = 9'd3; r1 = 1'b1;
        wait_rd_request(10, w);
        checks++; if (w != 2 || rdaddr_o !== 23'h000A00 || rdlen_o !== 9'd3) begin failures++; $display("FAIL rst_next_issue: got wait %0d %h/%0d want 2/000A00/3", w, rdaddr_o, rdlen_o); end
        step();
        feed(3, 32'hAA00_0000, 1'b0, av0, av1, dn0, dn1, bad, rq, ov, ld);
        checks++; if (av1 != 3 || av0 != 0 || ld !== 2'b10 || bad != 0) begin failures++; $display("FAIL rst_next_burst: got av1 %0d av0 %0d last %b bad %0d want 3/0/10/0", av1, av0, ld, bad); end
    endtask

    initial begin
        test_reset();
        test_single_port0();
        test_simultaneous();
        test_starvation();
        test_overrun();
        test_zero_len_timeout();
        test_reset_mid_burst();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
